cache_axi_arbiter: RTL and testbench

- Two-port request arbiter upstream of axi_rw's user port.
- Port 0 is the instruction-cache refill/fetch path; port 1 is the data-cache refill/writeback path.
- Selects one block-level read/write request at a time with round-robin priority, registers it, and drives the axi_rw user handshake.
- Routes the single-cycle completion (ready/rdata/resp) back to the originating port only.

---
 rtl/cache_axi_arbiter_if.sv | 64 ++++++
 rtl/cache_axi_arbiter.sv | 110 +++++++++++
 tb/tb_cache_axi_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_axi_arbiter_if.sv
// Request/completion bundle between the two cache ports, the arbiter
// and the axi_rw user port.
interface cache_axi_arbiter_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 64
);
  logic              p0_valid_i;
  logic              p0_req_i;
  logic [ADDR_W-1:0] p0_addr_i;
  logic [DATA_W-1:0] p0_wdata_i;
  logic [1:0]        p0_size_i;
  logic [7:0]        p0_blks_i;
  logic              p0_ready_o;
  logic [DATA_W-1:0] p0_rdata_o;
  logic [1:0]        p0_resp_o;

  logic              p1_valid_i;
  logic              p1_req_i;
  logic [ADDR_W-1:0] p1_addr_i;
  logic [DATA_W-1:0] p1_wdata_i;
  logic [1:0]        p1_size_i;
  logic [7:0]        p1_blks_i;
  logic              p1_ready_o;
  logic [DATA_W-1:0] p1_rdata_o;
  logic [1:0]        p1_resp_o;

  logic              axi_valid_o;
  logic              axi_req_o;
  logic [ADDR_W-1:0] axi_addr_o;
  logic [DATA_W-1:0] axi_wdata_o;
  logic [1:0]        axi_size_o;
  logic [7:0]        axi_blks_o;
  logic              axi_ready_i;
  logic [DATA_W-1:0] axi_rdata_i;
  logic [1:0]        axi_resp_i;

  logic [1:0]        owner_o;

  modport master (
    input  p0_valid_i, p0_req_i, p0_addr_i,
    input  p0_wdata_i, p0_size_i, p0_blks_i,
    output p0_ready_o, p0_rdata_o, p0_resp_o,
    input  p1_valid_i, p1_req_i, p1_addr_i,
    input  p1_wdata_i, p1_size_i, p1_blks_i,
    output p1_ready_o, p1_rdata_o, p1_resp_o,
    output axi_valid_o, axi_req_o, axi_addr_o,
    output axi_wdata_o, axi_size_o, axi_blks_o,
    input  axi_ready_i, axi_rdata_i, axi_resp_i,
    output owner_o
  );

  modport slave (
    output p0_valid_i, p0_req_i, p0_addr_i,
    output p0_wdata_i, p0_size_i, p0_blks_i,
    input  p0_ready_o, p0_rdata_o, p0_resp_o,
    output p1_valid_i, p1_req_i, p1_addr_i,
    output p1_wdata_i, p1_size_i, p1_blks_i,
    input  p1_ready_o, p1_rdata_o, p1_resp_o,
    input  axi_valid_o, axi_req_o, axi_addr_o,
    input  axi_wdata_o, axi_size_o, axi_blks_o,
    output axi_ready_i, axi_rdata_i, axi_resp_i,
    input  owner_o
  );
endinterface

// File: rtl/cache_axi_arbiter.sv
// Round-robin arbiter between I-cache (port 0) and D-cache (port 1)
// block requests, feeding a single axi_rw user port.
module cache_axi_arbiter #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 64
) (
  input  logic           clk,
  input  logic           rst,
  cache_axi_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              rr_last_q;
  logic [1:0]        owner_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        size_q;
  logic [7:0]        blks_q;
  logic [DATA_W-1:0] p0_rdata_q, p1_rdata_q;
  logic [1:0]        p0_resp_q, p1_resp_q;
  logic              gnt0, gnt1, done;

  // rr_last_q = 1 means port 1 was served last, so port 0 wins a tie
  always_comb begin
    state_d = state_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt0 = bus.p0_valid_i & (~bus.p1_valid_i | rr_last_q);
        gnt1 = bus.p1_valid_i & (~bus.p0_valid_i | ~rr_last_q);
        if (gnt0 | gnt1) state_d = REQ;
      end
      REQ: begin
        if (bus.axi_ready_i) begin
          done    = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_last_q  <= 1'b1;
      owner_q    <= 2'b00;
      req_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      blks_q     <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
      p0_resp_q  <= '0;
      p1_resp_q  <= '0;
    end else begin
      state_q <= state_d;
      if (gnt0 | gnt1) begin
        rr_last_q <= gnt1;
        owner_q   <= gnt1 ? 2'b10 : 2'b01;
        req_q     <= gnt1 ? bus.p1_req_i   : bus.p0_req_i;
        addr_q    <= gnt1 ? bus.p1_addr_i  : bus.p0_addr_i;
        wdata_q   <= gnt1 ? bus.p1_wdata_i : bus.p0_wdata_i;
        size_q    <= gnt1 ? bus.p1_size_i  : bus.p0_size_i;
        blks_q    <= gnt1 ? bus.p1_blks_i  : bus.p0_blks_i;
      end
      if (done) begin
        if (owner_q[1]) begin
          p1_rdata_q <= bus.axi_rdata_i;
          p1_resp_q  <= bus.axi_resp_i;
        end else begin
          p0_rdata_q <= bus.axi_rdata_i;
          p0_resp_q  <= bus.axi_resp_i;
        end
      end
      if (state_q == RESP) owner_q <= 2'b00;
    end
  end

  logic in_req, in_resp;
  assign in_req  = (state_q == REQ);
  assign in_resp = (state_q == RESP);

  assign bus.axi_valid_o = in_req;
  assign bus.axi_req_o   = in_req & req_q;
  assign bus.axi_addr_o  = in_req ? addr_q  : '0;
  assign bus.axi_wdata_o = in_req ? wdata_q : '0;
  assign bus.axi_size_o  = in_req ? size_q  : '0;
  assign bus.axi_blks_o  = in_req ? blks_q  : '0;

  assign bus.p0_ready_o = in_resp & owner_q[0];
  assign bus.p1_ready_o = in_resp & owner_q[1];
  assign bus.p0_rdata_o = p0_rdata_q;
  assign bus.p1_rdata_o = p1_rdata_q;
  assign bus.p0_resp_o  = p0_resp_q;
  assign bus.p1_resp_o  = p1_resp_q;
  assign bus.owner_o    = owner_q;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed and random bench for cache_axi_arbiter against a
// transaction-level model of the two-port round-robin arbiter.
module tb_cache_axi_arbiter;
  localparam int DW = 512;
  localparam int AW = 64;

  typedef struct packed {
    logic          req;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [1:0]    size;
    logic [7:0]    blks;
  } req_t;

  typedef enum {K_FREE, K_SERVE, K_DONE} kind_e;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_axi_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  cache_axi_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic any_out();
    return |{bus.p0_ready_o, bus.p0_rdata_o, bus.p0_resp_o,
             bus.p1_ready_o, bus.p1_rdata_o, bus.p1_resp_o,
             bus.axi_valid_o, bus.axi_req_o, bus.axi_addr_o,
             bus.axi_wdata_o, bus.axi_size_o, bus.axi_blks_o,
             bus.owner_o};
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    r.req   = 1'($urandom_range(1));
    r.addr  = {$urandom, $urandom};
    r.wdata = rnd_data();
    r.size  = 2'($urandom_range(3));
    r.blks  = 8'($urandom_range(255));
    return r;
  endfunction

  function automatic req_t port_req(input int p);
    req_t r;
    if (p == 0) begin
      r.req = bus.p0_req_i;  r.addr = bus.p0_addr_i;
      r.wdata = bus.p0_wdata_i;
      r.size = bus.p0_size_i; r.blks = bus.p0_blks_i;
    end else begin
      r.req = bus.p1_req_i;  r.addr = bus.p1_addr_i;
      r.wdata = bus.p1_wdata_i;
      r.size = bus.p1_size_i; r.blks = bus.p1_blks_i;
    end
    return r;
  endfunction

  // requester state driven onto the interface
  logic rv [2];
  req_t rf [2];

  task automatic apply();
    bus.p0_valid_i = rv[0];
    bus.p0_req_i   = rf[0].req;   bus.p0_addr_i = rf[0].addr;
    bus.p0_wdata_i = rf[0].wdata;
    bus.p0_size_i  = rf[0].size;  bus.p0_blks_i = rf[0].blks;
    bus.p1_valid_i = rv[1];
    bus.p1_req_i   = rf[1].req;   bus.p1_addr_i = rf[1].addr;
    bus.p1_wdata_i = rf[1].wdata;
    bus.p1_size_i  = rf[1].size;  bus.p1_blks_i = rf[1].blks;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] resp, input logic [DW-1:0] d);
    bus.axi_ready_i = 1'b1;
    bus.axi_rdata_i = d;
    bus.axi_resp_i  = resp;
  endtask

  // model state
  kind_e         pk = K_FREE;
  logic          m_last = 1'b1;
  logic          m_own = 1'b0;
  req_t          e;
  logic          prev_done = 1'b0;
  logic [DW-1:0] prev_rdata;
  logic [1:0]    prev_resp;
  logic          pv [2];
  req_t          pf [2];
  logic [DW-1:0] hold_rdata [2];
  logic [1:0]    hold_resp [2];
  int            waitc [2];
  int            n_txn = 0;
  logic          got_rdy [2];
  logic          s_axi_valid = 1'b0;

  always @(negedge clk) begin : mon
    kind_e      k;
    logic [1:0] eo;
    if (!rst) begin
      chk("reset_out", DW'(any_out()), '0);
      pk = K_FREE; m_last = 1'b1; prev_done = 1'b0;
      for (int p = 0; p < 2; p++) begin
        pv[p] = 1'b0; hold_rdata[p] = '0; hold_resp[p] = '0;
        waitc[p] = 0; got_rdy[p] = 1'b0;
      end
      s_axi_valid = 1'b0;
    end else begin
      if (pk == K_SERVE) begin
        k = prev_done ? K_DONE : K_SERVE;
      end else if (pk == K_FREE && (pv[0] || pv[1])) begin
        k = K_SERVE;
        if (pv[0] && pv[1]) m_own = ~m_last;
        else                m_own = pv[1];
        m_last = m_own;
        e = pf[m_own];
        n_txn++;
      end else begin
        k = K_FREE;
      end
      if (k == K_DONE) begin
        hold_rdata[m_own] = prev_rdata;
        hold_resp[m_own]  = prev_resp;
      end
      chk("p0_ready", DW'(bus.p0_ready_o), DW'(k == K_DONE && !m_own));
      chk("p1_ready", DW'(bus.p1_ready_o), DW'(k == K_DONE && m_own));
      chk("p0_rdata", bus.p0_rdata_o, hold_rdata[0]);
      chk("p1_rdata", bus.p1_rdata_o, hold_rdata[1]);
      chk("p0_resp", DW'(bus.p0_resp_o), DW'(hold_resp[0]));
      chk("p1_resp", DW'(bus.p1_resp_o), DW'(hold_resp[1]));
      chk("axi_valid", DW'(bus.axi_valid_o), DW'(k == K_SERVE));
      if (k == K_SERVE) begin
        chk("axi_req", DW'(bus.axi_req_o), DW'(e.req));
        chk("axi_addr", DW'(bus.axi_addr_o), DW'(e.addr));
        chk("axi_wdata", bus.axi_wdata_o, e.wdata);
        chk("axi_size", DW'(bus.axi_size_o), DW'(e.size));
        chk("axi_blks", DW'(bus.axi_blks_o), DW'(e.blks));
      end else begin
        chk("axi_bus_zero", DW'(|{bus.axi_req_o, bus.axi_addr_o,
            bus.axi_wdata_o, bus.axi_size_o, bus.axi_blks_o}), '0);
      end
      eo = (k == K_FREE) ? 2'b00 : (m_own ? 2'b10 : 2'b01);
      chk("owner", DW'(bus.owner_o), DW'(eo));
      pv[0] = bus.p0_valid_i;
      pv[1] = bus.p1_valid_i;
      for (int p = 0; p < 2; p++) begin
        pf[p] = port_req(p);
        waitc[p] = pv[p] ? waitc[p] + 1 : 0;
        if (waitc[p] == 300) chk("wait_timeout", DW'(waitc[p]), '0);
      end
      pk         = k;
      prev_done  = (k == K_SERVE) && bus.axi_ready_i;
      prev_rdata = bus.axi_rdata_i;
      prev_resp  = bus.axi_resp_i;
      got_rdy[0] = bus.p0_ready_o;
      got_rdy[1] = bus.p1_ready_o;
      s_axi_valid = bus.axi_valid_o;
    end
  end

  int lat = 0;

  initial begin
    for (int p = 0; p < 2; p++) begin
      rv[p] = 1'b0;
      rf[p] = '0;
    end
    apply();
    bus.axi_ready_i = 1'b0;
    bus.axi_rdata_i = '0;
    bus.axi_resp_i  = '0;
    rst = 1'b0;
    #1;
    chk("d_reset_out", DW'(any_out()), '0);
    repeat (2) step();
    rst = 1'b1;
    step();

    // single read from port 0
    rv[0] = 1'b1;
    rf[0] = '{req: 1'b0, addr: 64'h8000_0000, wdata: '0,
              size: 2'd3, blks: 8'd7};
    apply();
    step();
    chk("d_rd_valid", DW'(bus.axi_valid_o), DW'(1'b1));
    chk("d_rd_addr", DW'(bus.axi_addr_o), DW'(64'h8000_0000));
    chk("d_rd_size", DW'(bus.axi_size_o), DW'(2'd3));
    chk("d_rd_blks", DW'(bus.axi_blks_o), DW'(8'd7));
    chk("d_rd_req", DW'(bus.axi_req_o), '0);
    rf[0].addr = 64'hDEAD;
    apply();
    repeat (5) step();
    chk("d_stable_addr", DW'(bus.axi_addr_o), DW'(64'h8000_0000));
    pulse(2'b00, {64{8'hA5}});
    step();
    bus.axi_ready_i = 1'b0;
    chk("d_rd_p0_ready", DW'(bus.p0_ready_o), DW'(1'b1));
    chk("d_rd_p0_rdata", bus.p0_rdata_o, {64{8'hA5}});
    chk("d_rd_p1_ready", DW'(bus.p1_ready_o), '0);
    step();
    rv[0] = 1'b0;
    apply();
    chk("d_rd_pulse_len", DW'(bus.p0_ready_o), '0);
    step();

    // simultaneous requests straight out of reset
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    rv[0] = 1'b1;
    rf[0] = '{req: 1'b0, addr: 64'h8000_0040, wdata: '0,
              size: 2'd3, blks: 8'd7};
    rv[1] = 1'b1;
    rf[1] = '{req: 1'b1, addr: 64'h8000_1000, wdata: DW'(16'h1234),
              size: 2'd3, blks: 8'd7};
    apply();
    step();
    chk("d_sim_owner0", DW'(bus.owner_o), DW'(2'b01));
    chk("d_sim_addr0", DW'(bus.axi_addr_o), DW'(64'h8000_0040));
    step();
    pulse(2'b00, rnd_data());
    step();
    bus.axi_ready_i = 1'b0;
    chk("d_sim_p0_ready", DW'(bus.p0_ready_o), DW'(1'b1));
    step();
    rv[0] = 1'b0;
    apply();
    step();
    chk("d_sim_owner1", DW'(bus.owner_o), DW'(2'b10));
    chk("d_sim_req1", DW'(bus.axi_req_o), DW'(1'b1));
    chk("d_sim_addr1", DW'(bus.axi_addr_o), DW'(64'h8000_1000));
    chk("d_sim_wdata1", bus.axi_wdata_o, DW'(16'h1234));
    pulse(2'b10, rnd_data());
    step();
    bus.axi_ready_i = 1'b0;
    chk("d_err_p1_ready", DW'(bus.p1_ready_o), DW'(1'b1));
    chk("d_err_p1_resp", DW'(bus.p1_resp_o), DW'(2'b10));
    chk("d_err_p0_ready", DW'(bus.p0_ready_o), '0);
    step();
    rv[1] = 1'b0;
    apply();
    step();

    // reset in the middle of a request
    rv[0] = 1'b1;
    rf[0] = rnd_req();
    apply();
    step();
    chk("d_mid_valid", DW'(bus.axi_valid_o), DW'(1'b1));
    #2;
    rst = 1'b0;
    #1;
    chk("d_mid_async", DW'(any_out()), '0);
    rv[0] = 1'b0;
    apply();
    repeat (2) step();
    rst = 1'b1;
    rv[0] = 1'b1; rf[0] = rnd_req();
    rv[1] = 1'b1; rf[1] = rnd_req();
    apply();
    step();
    chk("d_mid_tie_owner", DW'(bus.owner_o), DW'(2'b01));

    // random traffic; the first stretch keeps both ports saturated
    for (int c = 0; c < 4000; c++) begin
      step();
      for (int p = 0; p < 2; p++) begin
        if (got_rdy[p]) begin
          rv[p] = 1'b0;
        end else if (!rv[p]) begin
          if (c < 400 || $urandom_range(3) == 0) begin
            rv[p] = 1'b1;
            rf[p] = rnd_req();
          end
        end else if ($urandom_range(15) == 0) begin
          rf[p] = rnd_req();
        end
      end
      apply();
      if (bus.axi_ready_i) begin
        bus.axi_ready_i = 1'b0;
      end else if (s_axi_valid) begin
        if (lat == 0) begin
          pulse(2'($urandom_range(3)), rnd_data());
          lat = (c < 400) ? 0 : int'($urandom_range(4));
        end else begin
          lat--;
        end
      end else if ($urandom_range(19) == 0) begin
        pulse(2'($urandom_range(3)), rnd_data());
      end
    end
    step();
    chk("txn_progress", DW'(n_txn > 300), DW'(1'b1));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
